ws2812_frame_ctrl: RTL and testbench

- Frame sequencer that sits upstream of the team's single-bit WS2812 code driver.
- Accepts 24-bit GRB pixel words over a valid/ready handshake and serializes each word MSB-first into the driver's code/valid/ready interface, one bit per driver handshake.
- After LED_NUM pixels it waits for the driver to finish the last bit, then holds the line idle for RESET_CYCLES to latch the LED chain, and pulses frame_done_out.

---
 rtl/ws2812_frame_ctrl.sv | 121 ++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_ctrl.sv
// Purpose: frame sequencer feeding 24-bit GRB pixels MSB-first, one bit per handshake, into a WS2812 code driver.
// Latency: first bit is offered 2 cycles after start_in; frame_done_out pulses RESET_CYCLES cycles after the drain ends.
// Backpressure: each bit is held on code_out until drv_ready_in; pixel_ready_out is high only while waiting for a pixel.
module ws2812_frame_ctrl #(
  parameter int LED_NUM      = 4,
  parameter int LED_CNT_W    = 8,
  parameter int RESET_CYCLES = 16,
  parameter int RST_CNT_W    = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        start_in,
  input  logic [23:0] pixel_data_in,
  input  logic        pixel_valid_in,
  output logic        pixel_ready_out,
  output logic        code_out,
  output logic        code_valid_out,
  input  logic        drv_ready_in,
  output logic        busy_out,
  output logic        frame_done_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DRAIN,
    S_LATCH
  } state_t;

  localparam logic [LED_CNT_W-1:0] LED_LAST = LED_CNT_W'(LED_NUM - 1);
  localparam logic [RST_CNT_W-1:0] RST_LAST = RST_CNT_W'(RESET_CYCLES - 1);

  state_t               state_q, state_d;
  logic [23:0]          shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d;
  logic [LED_CNT_W-1:0] led_cnt_q, led_cnt_d;
  logic [RST_CNT_W-1:0] rst_cnt_q, rst_cnt_d;

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      led_cnt_q <= '0;
      rst_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      led_cnt_q <= led_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Next-state and counter updates; inputs only ever steer the next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    led_cnt_d = led_cnt_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          led_cnt_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (pixel_valid_in) begin
          shift_d   = pixel_data_in;
          bit_cnt_d = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        // code_valid_out is constantly high here, so drv_ready_in alone marks a handshake.
        if (drv_ready_in) begin
          shift_d   = {shift_q[22:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            if (led_cnt_q == LED_LAST) begin
              state_d = S_DRAIN;
            end else begin
              led_cnt_d = led_cnt_q + LED_CNT_W'(1);
              state_d   = S_LOAD;
            end
          end
        end
      end
      S_DRAIN: begin
        // Ready returning high means the last bit's low phase has completed.
        if (drv_ready_in) begin
          rst_cnt_d = '0;
          state_d   = S_LATCH;
        end
      end
      S_LATCH: begin
        rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded purely from registers; no input-to-output path.
  always_comb begin
    pixel_ready_out = (state_q == S_LOAD);
    code_valid_out  = (state_q == S_SEND);
    code_out        = shift_q[23];
    busy_out        = (state_q != S_IDLE);
    frame_done_out  = (state_q == S_LATCH) && (rst_cnt_q == RST_LAST);
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Purpose: self-checking bench for ws2812_frame_ctrl with behavioural driver models.
// Latency: expected bits and frame_done cycles are queued at issue time and checked by monitors.
// Backpressure: driver models drop ready for BIT_CYC cycles after each accepted bit.
module tb_ws2812_frame_ctrl;

  localparam int BIT_CYC = 6;
  localparam int MAXW    = 5000;
  localparam int NLED    = 4;
  localparam int NRST    = 16;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [23:0] pixel_data_in;
  logic        pixel_valid_in;
  logic        pixel_ready_out;
  logic        code_out;
  logic        code_valid_out;
  logic        drv_ready_in;
  logic        busy_out;
  logic        frame_done_out;

  logic        start1;
  logic [23:0] data1;
  logic        valid1;
  logic        ready1;
  logic        code1;
  logic        cv1;
  logic        drv_rdy1;
  logic        busy1;
  logic        done1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_total = 0;
  int frame_hs = 0;
  int n_done = 0;
  bit wait_drain = 0;
  int drv_cnt, drv_cnt1;
  int hs1 = 0;
  int n_done1 = 0;
  bit wait1 = 0;

  bit exp_bits[$];
  int exp_done[$];
  bit exp_bits1[$];
  int exp_done1[$];

  always #5 clk_in = ~clk_in;

  ws2812_frame_ctrl #(.LED_NUM(NLED), .LED_CNT_W(8), .RESET_CYCLES(NRST), .RST_CNT_W(16)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .pixel_data_in(pixel_data_in), .pixel_valid_in(pixel_valid_in), .pixel_ready_out(pixel_ready_out),
    .code_out(code_out), .code_valid_out(code_valid_out), .drv_ready_in(drv_ready_in),
    .busy_out(busy_out), .frame_done_out(frame_done_out)
  );

  ws2812_frame_ctrl #(.LED_NUM(1), .LED_CNT_W(1), .RESET_CYCLES(1), .RST_CNT_W(1)) dut1 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start1),
    .pixel_data_in(data1), .pixel_valid_in(valid1), .pixel_ready_out(ready1),
    .code_out(code1), .code_valid_out(cv1), .drv_ready_in(drv_rdy1),
    .busy_out(busy1), .frame_done_out(done1)
  );

  // Behavioural drivers: busy for BIT_CYC cycles after each accepted bit.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) drv_cnt <= 0;
    else if (code_valid_out && drv_ready_in) drv_cnt <= BIT_CYC;
    else if (drv_cnt != 0) drv_cnt <= drv_cnt - 1;
  end
  assign drv_ready_in = (drv_cnt == 0);

  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) drv_cnt1 <= 0;
    else if (cv1 && drv_rdy1) drv_cnt1 <= BIT_CYC;
    else if (drv_cnt1 != 0) drv_cnt1 <= drv_cnt1 - 1;
  end
  assign drv_rdy1 = (drv_cnt1 == 0);

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the LED_NUM=4 instance: bit order, handshake count, frame_done timing.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (code_valid_out && drv_ready_in) begin
        hs_total++;
        frame_hs++;
        if (exp_bits.size() == 0) chk("unexpected_bit", 1, 0);
        else chk("code_bit", int'(code_out), int'(exp_bits.pop_front()));
        if (frame_hs == 24 * NLED) wait_drain = 1;
      end else if (wait_drain && drv_ready_in) begin
        exp_done.push_back(cyc + NRST);
        wait_drain = 0;
      end
      if (frame_done_out) begin
        n_done++;
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, exp_done.pop_front());
        chk("frame_handshakes", frame_hs, 24 * NLED);
        chk("busy_at_done", int'(busy_out), 1);
        frame_hs = 0;
      end
    end
  end

  // Monitor for the LED_NUM=1, RESET_CYCLES=1 instance.
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (cv1 && drv_rdy1) begin
        hs1++;
        if (exp_bits1.size() == 0) chk("u1_unexpected_bit", 1, 0);
        else chk("u1_code_bit", int'(code1), int'(exp_bits1.pop_front()));
        if (hs1 == 24) wait1 = 1;
      end else if (wait1 && drv_rdy1) begin
        exp_done1.push_back(cyc + 1);
        wait1 = 0;
      end
      if (done1) begin
        n_done1++;
        if (exp_done1.size() == 0) chk("u1_unexpected_done", 1, 0);
        else chk("u1_done_cycle", cyc, exp_done1.pop_front());
        chk("u1_handshakes", hs1, 24);
      end
    end
  end

  task automatic push_bits(input logic [23:0] p);
    for (int i = 23; i >= 0; i--) exp_bits.push_back(p[i]);
  endtask

  // Present a pixel and wait until accepted; returns on a negedge.
  task automatic send_pixel(input logic [23:0] p);
    int k = 0;
    pixel_data_in  = p;
    pixel_valid_in = 1'b1;
    while (!pixel_ready_out && k < MAXW) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= MAXW) chk("timeout_pixel_ready", 0, 1);
    else begin
      @(posedge clk_in);
      push_bits(p);
      @(negedge clk_in);
    end
  endtask

  task automatic wait_hs(input int n);
    int k = 0;
    while (hs_total < n && k < MAXW) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= MAXW) chk("timeout_handshakes", hs_total, n);
  endtask

  task automatic wait_done();
    int k = 0;
    while (!frame_done_out && k < MAXW) begin
      @(negedge clk_in);
      k++;
    end
    if (k >= MAXW) chk("timeout_frame_done", 0, 1);
  endtask

  task automatic pulse_start_check_busy(input string name);
    chk({name, "_busy_before"}, int'(busy_out), 0);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    chk({name, "_busy_after"}, int'(busy_out), 1);
  endtask

  initial begin
    int k;
    rst_n_in = 1'b0; start_in = 1'b0; pixel_valid_in = 1'b0; pixel_data_in = '0;
    start1 = 1'b0; valid1 = 1'b0; data1 = '0;
    repeat (3) @(negedge clk_in);
    chk("reset_outputs", int'({pixel_ready_out, code_out, code_valid_out, busy_out, frame_done_out}), 0);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("idle_outputs", int'({pixel_ready_out, code_out, code_valid_out, busy_out, frame_done_out}), 0);

    // Frame 1: known pattern, start during SEND, 10-cycle stall before pixel 3, start during LATCH.
    pulse_start_check_busy("f1");
    send_pixel(24'hA50FC3);
    start_in = 1'b1;
    chk("in_send_code_valid", int'(code_valid_out), 1);
    @(negedge clk_in);
    start_in = 1'b0;
    send_pixel(24'h123456);
    pixel_valid_in = 1'b0;
    k = 0;
    while (!pixel_ready_out && k < MAXW) begin @(negedge clk_in); k++; end
    for (int i = 0; i < 10; i++) begin
      chk("stall_ready_noval", int'({pixel_ready_out, code_valid_out}), 2);
      @(negedge clk_in);
    end
    send_pixel(24'h800001);
    send_pixel(24'hFFFFFF);
    wait_hs(96);
    k = 0;
    while (!(drv_ready_in && !code_valid_out) && k < MAXW) begin @(negedge clk_in); k++; end
    repeat (3) @(negedge clk_in);
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done();

    // Frame 2: start in the first idle cycle after frame_done.
    @(negedge clk_in);
    pulse_start_check_busy("b2b");
    send_pixel(24'h000000);
    send_pixel(24'hA50FC3);
    send_pixel(24'h7E7E7E);
    send_pixel(24'hC0FFEE);
    wait_done();

    // Frame 3: reset asserted after bit 40.
    @(negedge clk_in);
    pulse_start_check_busy("f3");
    send_pixel(24'h3C3C3C);
    send_pixel(24'h5A5A5A);
    wait_hs(192 + 40);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("mid_reset_outputs", int'({pixel_ready_out, code_out, code_valid_out, busy_out, frame_done_out}), 0);
    exp_bits.delete();
    exp_done.delete();
    frame_hs = 0;
    wait_drain = 0;
    pixel_valid_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    // Frame 4: clean full frame after reset.
    pulse_start_check_busy("f4");
    send_pixel(24'hDEADBE);
    send_pixel(24'h010203);
    send_pixel(24'hF0F0F0);
    send_pixel(24'h55AA55);
    pixel_valid_in = 1'b0;
    wait_done();
    @(negedge clk_in);

    // Single-LED, single-cycle-latch build.
    chk("u1_idle_busy", int'(busy1), 0);
    start1 = 1'b1;
    @(negedge clk_in);
    start1 = 1'b0;
    chk("u1_busy_after", int'(busy1), 1);
    data1  = 24'h3C5A96;
    valid1 = 1'b1;
    k = 0;
    while (!ready1 && k < MAXW) begin @(negedge clk_in); k++; end
    if (k >= MAXW) chk("u1_timeout_ready", 0, 1);
    @(posedge clk_in);
    for (int i = 23; i >= 0; i--) exp_bits1.push_back(data1[i]);
    @(negedge clk_in);
    valid1 = 1'b0;
    k = 0;
    while (!done1 && k < MAXW) begin @(negedge clk_in); k++; end
    if (k >= MAXW) chk("u1_timeout_done", 0, 1);
    repeat (3) @(negedge clk_in);

    chk("bits_left", exp_bits.size(), 0);
    chk("done_left", exp_done.size(), 0);
    chk("frames_done", n_done, 3);
    chk("u1_bits_left", exp_bits1.size(), 0);
    chk("u1_frames_done", n_done1, 1);
    chk("final_idle", int'({busy_out, busy1}), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
